// File: rtl/mux_seq_ctrl.sv
// Truth-table scanner for an external 8:1 mux: steps sel 0..7, samples mux_y into result.
// Optional macro MUX_SEQ_CTRL_PARITY_EN adds a registered result_parity output.
module mux_seq_ctrl #(
    parameter int unsigned SETTLE = 0  // legal range 0..3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] table_in,
    input  logic [7:0] expect_in,
    output logic [7:0] table_q,
    output logic [2:0] sel,
    input  logic       mux_y,
    output logic [7:0] result,
    output logic       match,
    output logic       result_valid,
    input  logic       result_ready,
`ifdef MUX_SEQ_CTRL_PARITY_EN
    output logic       result_parity,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [1:0] SettleLast = 2'(SETTLE);

    state_e     state_q, state_d;
    logic [7:0] table_d;
    logic [7:0] expect_q, expect_d;
    logic [2:0] sel_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] result_d;
    logic [7:0] cap;
    logic       match_d;
`ifdef MUX_SEQ_CTRL_PARITY_EN
    logic       parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            table_q  <= '0;
            expect_q <= '0;
            sel      <= '0;
            cnt_q    <= '0;
            result   <= '0;
            match    <= 1'b0;
`ifdef MUX_SEQ_CTRL_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            table_q  <= table_d;
            expect_q <= expect_d;
            sel      <= sel_d;
            cnt_q    <= cnt_d;
            result   <= result_d;
            match    <= match_d;
`ifdef MUX_SEQ_CTRL_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        table_d  = table_q;
        expect_d = expect_q;
        sel_d    = sel;
        cnt_d    = cnt_q;
        result_d = result;
        match_d  = match;
`ifdef MUX_SEQ_CTRL_PARITY_EN
        parity_d = parity_q;
`endif
        // Result as it will look once the current select has been sampled.
        cap      = result;
        cap[sel] = mux_y;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    table_d  = table_in;
                    expect_d = expect_in;
                    sel_d    = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    match_d  = 1'b0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                if (cnt_q == SettleLast) begin
                    cnt_d    = '0;
                    result_d = cap;
                    if (sel == 3'd7) begin
                        sel_d   = '0;
                        match_d = (cap == expect_q);
`ifdef MUX_SEQ_CTRL_PARITY_EN
                        parity_d = ^cap;
`endif
                        state_d = StDone;
                    end else begin
                        sel_d = sel + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDone: begin
                // match/parity are only meaningful while result_valid is high.
                if (result_ready) begin
                    match_d = 1'b0;
`ifdef MUX_SEQ_CTRL_PARITY_EN
                    parity_d = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign start_ready  = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
`ifdef MUX_SEQ_CTRL_PARITY_EN
    assign result_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Directed scoreboard bench for mux_seq_ctrl: one instance with SETTLE=0, one with SETTLE=2.
module tb_mux_seq_ctrl;

    typedef struct packed {
        logic [7:0] res;
        logic       m;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk, rst;

    logic       sv0, rdy0, y0, m0, rv0, rr0, busy0, par0;
    logic [7:0] tin0, ein0, tq0, res0;
    logic [2:0] sel0;

    logic       sv2, rdy2, y2, m2, rv2, rr2, busy2, par2;
    logic [7:0] tin2, ein2, tq2, res2;
    logic [2:0] sel2;

    // Behavioural external 8:1 mux.
    assign y0 = tq0[sel0];
    assign y2 = tq2[sel2];

    mux_seq_ctrl #(.SETTLE(0)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (sv0),
        .start_ready  (rdy0),
        .table_in     (tin0),
        .expect_in    (ein0),
        .table_q      (tq0),
        .sel          (sel0),
        .mux_y        (y0),
        .result       (res0),
        .match        (m0),
        .result_valid (rv0),
        .result_ready (rr0),
`ifdef MUX_SEQ_CTRL_PARITY_EN
        .result_parity(par0),
`endif
        .busy         (busy0)
    );

    mux_seq_ctrl #(.SETTLE(2)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (sv2),
        .start_ready  (rdy2),
        .table_in     (tin2),
        .expect_in    (ein2),
        .table_q      (tq2),
        .sel          (sel2),
        .mux_y        (y2),
        .result       (res2),
        .match        (m2),
        .result_valid (rv2),
        .result_ready (rr2),
`ifdef MUX_SEQ_CTRL_PARITY_EN
        .result_parity(par2),
`endif
        .busy         (busy2)
    );

`ifndef MUX_SEQ_CTRL_PARITY_EN
    assign par0 = 1'b0;
    assign par2 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [7:0] t, input logic [7:0] e);
        exp_t x;
        x.res = t;  // ideal mux: bit i of the pattern appears at sel=i
        x.m   = (t == e);
        x.p   = ^t;
        return x;
    endfunction

    task automatic start0(input logic [7:0] t, input logic [7:0] e);
        check("start_ready0_idle", rdy0, 1);
        tin0 = t; ein0 = e; sv0 = 1'b1;
        sb.push_back(model(t, e));
        step();
        sv0 = 1'b0;
    endtask

    task automatic start2(input logic [7:0] t, input logic [7:0] e);
        check("start_ready2_idle", rdy2, 1);
        tin2 = t; ein2 = e; sv2 = 1'b1;
        sb.push_back(model(t, e));
        step();
        sv2 = 1'b0;
    endtask

    task automatic pop(output exp_t e);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
    endtask

    // Called in the first cycle after the accepting edge.
    task automatic wait_done0();
        int   n = 1;
        exp_t e;
        while (!rv0 && n < 40) begin
            check("sel0_step", sel0, n - 1);
            step();
            n++;
        end
        check("latency0", n, 9);
        pop(e);
        check("result0", res0, e.res);
        check("match0", m0, e.m);
        check("sel0_done", sel0, 0);
        check("start_ready0_done", rdy0, 0);
`ifdef MUX_SEQ_CTRL_PARITY_EN
        check("parity0", par0, e.p);
`endif
    endtask

    task automatic wait_done2();
        int   n = 1;
        exp_t e;
        while (!rv2 && n < 60) begin
            check("sel2_step", sel2, (n - 1) / 3);
            step();
            n++;
        end
        check("latency2", n, 25);
        pop(e);
        check("result2", res2, e.res);
        check("match2", m2, e.m);
`ifdef MUX_SEQ_CTRL_PARITY_EN
        check("parity2", par2, e.p);
`endif
    endtask

    task automatic ack0();
        rr0 = 1'b1;
        step();
        rr0 = 1'b0;
        check("rv0_after_ack", rv0, 0);
        check("match0_after_ack", m0, 0);
        check("busy0_after_ack", busy0, 0);
`ifdef MUX_SEQ_CTRL_PARITY_EN
        check("parity0_after_ack", par0, 0);
`endif
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        sv0 = 0; tin0 = 0; ein0 = 0; rr0 = 0;
        sv2 = 0; tin2 = 0; ein2 = 0; rr2 = 0;
        step();
        step();
        check("rst_start_ready", rdy0, 1);
        check("rst_table_q", tq0, 0);
        check("rst_sel", sel0, 0);
        check("rst_result", res0, 0);
        check("rst_match", m0, 0);
        check("rst_valid", rv0, 0);
        check("rst_busy", busy0, 0);
        rst = 1'b0;
        step();

        // Matching scan, then mismatching scan.
        start0(8'h96, 8'h96);
        wait_done0();
        ack0();
        start0(8'h71, 8'h96);
        wait_done0();
        ack0();

        // Back-pressure in DONE with start held high.
        start0(8'h5A, 8'h5A);
        wait_done0();
        tin0 = 8'hFF; ein0 = 8'hFF; sv0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", rv0, 1);
            check("hold_result", res0, 8'h5A);
            check("hold_match", m0, 1);
            check("hold_start_ready", rdy0, 0);
            check("hold_table_q", tq0, 8'h5A);
        end
        sb.push_back(model(8'hFF, 8'hFF));
        rr0 = 1'b1;
        step();
        rr0 = 1'b0;
        check("handshake_idle", rdy0, 1);
        check("handshake_no_start", tq0, 8'h5A);
        check("handshake_valid", rv0, 0);
        step();
        sv0 = 1'b0;
        check("late_start_busy", busy0, 1);
        check("late_start_table", tq0, 8'hFF);
        wait_done0();
        ack0();

        // Reset mid-scan at sel=4, with start_valid also high.
        start0(8'hC3, 8'hC3);
        for (int i = 0; i < 4; i++) step();
        check("mid_sel", sel0, 4);
        rst = 1'b1; sv0 = 1'b1;
        step();
        rst = 1'b0; sv0 = 1'b0;
        void'(sb.pop_back());
        check("midrst_sel", sel0, 0);
        check("midrst_result", res0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_valid", rv0, 0);
        check("midrst_table", tq0, 0);
        start0(8'h3C, 8'h3C);
        wait_done0();
        ack0();

        start0(8'h01, 8'h01);
        wait_done0();
        ack0();

        // SETTLE=2 instance.
        start2(8'h96, 8'h96);
        wait_done2();
        rr2 = 1'b1;
        step();
        rr2 = 1'b0;
        check("rv2_after_ack", rv2, 0);
        check("busy2_after_ack", busy2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_seq_ctrl.md
MUX_SEQ_CTRL -- requirements
Module: mux_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 0, meaning wait cycles after each select change before sampling; legal range 0..3.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_valid  input  1  request to begin a truth-table scan.
REQ-005 SHALL have port start_ready  output  1  controller can accept a start.
REQ-006 SHALL have port table_in  input  8  mux data-input pattern, bit i drives mux input i.
REQ-007 SHALL have port expect_in  input  8  expected output vector, bit i for select i.
REQ-008 SHALL have port table_q  output  8  latched pattern driven to the external 8:1 mux data bus.
REQ-009 SHALL have port sel  output  3  select driven to the external 8:1 mux.
REQ-010 SHALL have port mux_y  input  1  combinational output of the external 8:1 mux.
REQ-011 SHALL have port result  output  8  captured outputs, bit i sampled at sel=i.
REQ-012 SHALL have port match  output  1  result equals latched expect vector.
REQ-013 SHALL have port result_valid  output  1  result/match valid.
REQ-014 SHALL have port result_ready  input  1  consumer accepts result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-017 IDLE: start_ready=1; start accepted when start_valid=1 at a rising edge; table_in to table_q, expect_in to internal expect_q, sel=0, settle counter=0, result=0, next state SCAN.
REQ-018 start_ready SHALL be 0 in SCAN and DONE; start_valid there SHALL be ignored and table_q/expect_q SHALL not change.
REQ-019 SCAN: settle counter increments each cycle; when counter==SETTLE, result[sel] captures mux_y at that edge, counter clears, and sel increments (if sel<7) or the state goes to DONE (if sel==7).
REQ-020 sel SHALL hold its value for exactly SETTLE+1 cycles per index; sel SHALL not wrap past 7 inside a scan; sel SHALL return to 0 on entry to DONE.
REQ-021 Latency: start accepted at edge of cycle T gives result_valid=1 first in cycle T+1+8*(SETTLE+1) (T+9 for SETTLE=0).
REQ-022 DONE: result_valid=1; result, match, table_q held stable until result_ready=1 at a rising edge; then next state IDLE and result_valid=0.
REQ-023 match SHALL be (result==expect_q) registered with result; match SHALL be 0 whenever result_valid=0.
REQ-024 A start presented in the same cycle as the DONE-to-IDLE handshake SHALL not be accepted; it is accepted earliest in the following IDLE cycle.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE from any state, including mid-scan, and abandon any partial result.
REQ-026 Reset values SHALL be: start_ready=1, table_q=0, sel=0, result=0, match=0, result_valid=0, busy=0, settle counter=0, expect_q=0.
REQ-027 rst SHALL take priority over start_valid and result_ready in the same cycle.

Configuration
REQ-028 With macro MUX_SEQ_CTRL_PARITY_EN defined, the block SHALL add output result_parity (1 bit) = XOR of result bits, registered with result, 0 on reset and whenever result_valid=0.
REQ-029 Without MUX_SEQ_CTRL_PARITY_EN the result_parity port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-030 SETTLE=0, bench mux y=table_q[sel]; start with table_in=0x96, expect_in=0x96 at T -> sel steps 0..7 in cycles T+1..T+8, result=0x96, match=1, result_valid in T+9.
REQ-031 SETTLE=0, table_in=0x71, expect_in=0x96 -> result=0x71, match=0, result_valid in T+9.
REQ-032 SETTLE=2, table_in=0x96 -> each sel value held 3 cycles, result_valid first in T+25, result=0x96.
REQ-033 result_ready=0 for 5 cycles in DONE, start_valid=1 throughout -> result/match stable, start_ready=0, no new scan; start accepted in the cycle after result_ready handshake.
REQ-034 rst=1 when sel=4 mid-scan -> next cycle IDLE, sel=0, result=0, busy=0, result_valid=0; a new start then gives a full correct scan.
REQ-035 With MUX_SEQ_CTRL_PARITY_EN: result 0x96 -> result_parity=0; result 0x71 -> result_parity=0; result 0x01 -> result_parity=1.
